parser: RTL and testbench

Token parser for the eForth1 outer interpreter; sits directly upstream of the dictionary word finder. It scans the terminal input buffer (TIB) from the current `>IN` offset, skips leading delimiters, and copies the next token into a counted-string buffer in the 8-bit memory block: a length byte followed by the characters. The finder then takes that buffer address as its `aw` input. The parser drives the memory block through the same `mb8_io` master port used by the finder; the two blocks share the port under top-level arbitration.

---
 rtl/parser_if.sv | 12 +
 rtl/parser.sv | 181 ++++++++++++++++++
 tb/tb_parser.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/parser_if.sv
// Master-side view of the 8-bit memory block port shared by the parser and the word finder.
interface mb8_io #(
  parameter int ASZ = 17,
  parameter int DSZ = 8
);
  logic [ASZ-1:0] ai;
  logic           we;
  logic [DSZ-1:0] vo;

  modport master (output ai, output we, output vo);
  modport slave  (input  ai, input  we, input  vo);
endinterface

// File: rtl/parser.sv
// eForth1 token parser: skips leading delimiters in the TIB from >IN and copies the next
// token into a counted-string buffer (length byte, then characters) for the word finder.
module parser #(
  parameter int DSZ  = 8,
  parameter int ASZ  = 17,
  parameter int TMAX = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  mb8_io.master          mb_if,
  input  logic           en,
  input  logic [ASZ-1:0] tib,
  input  logic [7:0]     ntib,
  input  logic [7:0]     toin,
  input  logic [ASZ-1:0] buf_addr,
  input  logic [DSZ-1:0] dlm,
  input  logic [DSZ-1:0] vw,
  output logic           bsy,
  output logic           ok,
  output logic [7:0]     len,
  output logic           trc,
  output logic [7:0]     toin_o,
  output logic [3:0]     st
);

  localparam logic [3:0] IDL = 4'd0;
  localparam logic [3:0] SRD = 4'd1;
  localparam logic [3:0] SWT = 4'd2;
  localparam logic [3:0] SCK = 4'd3;
  localparam logic [3:0] CWR = 4'd4;
  localparam logic [3:0] CRD = 4'd5;
  localparam logic [3:0] CWT = 4'd6;
  localparam logic [3:0] CCK = 4'd7;
  localparam logic [3:0] WRL = 4'd8;
  localparam logic [3:0] DON = 4'd9;

  logic [3:0]     st_q, st_d;
  logic           bsy_q, bsy_d, ok_q, ok_d, trc_q, trc_d;
  logic [7:0]     len_q, len_d, toin_o_q, toin_o_d;
  logic [7:0]     n_q, n_d, idx_q, idx_d;
  logic [ASZ-1:0] ai_q, ai_d;
  logic           we_q, we_d;
  logic [DSZ-1:0] vo_q, vo_d;
  logic           is_dlm, at_end;

  // A space delimiter also matches every control character (tab, CR, LF).
  assign is_dlm = (dlm == DSZ'(8'h20)) ? (vw <= DSZ'(8'h20)) : (vw == dlm);
  assign at_end = (idx_q >= ntib);

  always_comb begin
    st_d     = st_q;
    bsy_d    = bsy_q;
    ok_d     = ok_q;
    trc_d    = trc_q;
    len_d    = len_q;
    toin_o_d = toin_o_q;
    n_d      = n_q;
    idx_d    = idx_q;
    ai_d     = ai_q;
    we_d     = we_q;
    vo_d     = vo_q;
    if (!en && st_q != IDL && st_q != DON) begin
      st_d  = IDL;
      bsy_d = 1'b0;
      we_d  = 1'b0;
      ok_d  = 1'b0;
    end else begin
      case (st_q)
        IDL: begin
          we_d = 1'b0;
          if (en) begin
            bsy_d = 1'b1;
            ok_d  = 1'b0;
            trc_d = 1'b0;
            n_d   = 8'd0;
            idx_d = toin;
            st_d  = SRD;
          end
        end
        SRD: begin
          if (at_end) st_d = WRL;
          else begin
            ai_d = tib + ASZ'(idx_q);
            st_d = SWT;
          end
        end
        SWT: st_d = SCK;
        SCK: begin
          if (is_dlm) begin
            idx_d = idx_q + 8'd1;
            st_d  = SRD;
          end else st_d = CWR;
        end
        CWR: begin
          // Characters past TMAX are still consumed, just not stored.
          if (n_q < 8'(TMAX)) begin
            ai_d = buf_addr + ASZ'(n_q) + ASZ'(1);
            vo_d = vw;
            we_d = 1'b1;
            n_d  = n_q + 8'd1;
          end else trc_d = 1'b1;
          idx_d = idx_q + 8'd1;
          st_d  = CRD;
        end
        CRD: begin
          we_d = 1'b0;
          if (at_end) st_d = WRL;
          else begin
            ai_d = tib + ASZ'(idx_q);
            st_d = CWT;
          end
        end
        CWT: st_d = CCK;
        CCK: begin
          if (is_dlm) begin
            idx_d = idx_q + 8'd1;
            st_d  = WRL;
          end else st_d = CWR;
        end
        WRL: begin
          ai_d     = buf_addr;
          vo_d     = DSZ'(n_q);
          we_d     = 1'b1;
          len_d    = n_q;
          ok_d     = (n_q != 8'd0);
          toin_o_d = idx_q;
          bsy_d    = 1'b0;
          st_d     = DON;
        end
        DON: begin
          we_d = 1'b0;
          if (!en) st_d = IDL;
        end
        default: begin
          st_d  = IDL;
          bsy_d = 1'b0;
          we_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDL;
      bsy_q    <= 1'b0;
      ok_q     <= 1'b0;
      trc_q    <= 1'b0;
      len_q    <= 8'd0;
      toin_o_q <= 8'd0;
      n_q      <= 8'd0;
      idx_q    <= 8'd0;
      ai_q     <= '0;
      we_q     <= 1'b0;
      vo_q     <= '0;
    end else begin
      st_q     <= st_d;
      bsy_q    <= bsy_d;
      ok_q     <= ok_d;
      trc_q    <= trc_d;
      len_q    <= len_d;
      toin_o_q <= toin_o_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      ai_q     <= ai_d;
      we_q     <= we_d;
      vo_q     <= vo_d;
    end
  end

  assign mb_if.ai = ai_q;
  assign mb_if.we = we_q;
  assign mb_if.vo = vo_q;
  assign bsy      = bsy_q;
  assign ok       = ok_q;
  assign trc      = trc_q;
  assign len      = len_q;
  assign toin_o   = toin_o_q;
  assign st       = st_q;

endmodule

// File: tb/tb_parser.sv
// Directed bench for parser: a behavioural model predicts each token, results are queued
// at launch and popped when bsy falls, then checked along with the memory image.
module tb_parser;
  localparam int ASZ = 17, DSZ = 8, TMAX = 31;
  localparam logic [ASZ-1:0] TIB = 17'h100;
  localparam logic [ASZ-1:0] BUF = 17'h200;

  typedef struct packed {
    logic                  ok;
    logic [7:0]            len;
    logic                  trc;
    logic [7:0]            toin;
    logic [15:0]           lat;
    logic [TMAX-1:0][7:0]  ch;
  } exp_t;

  logic           clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [ASZ-1:0] tib_a = TIB, buf_a = BUF;
  logic [7:0]     ntib = 8'd0, toin = 8'd0;
  logic [DSZ-1:0] dlm = 8'h20, vw;
  logic           bsy, ok, trc;
  logic [7:0]     len, toin_o;
  logic [3:0]     st;

  logic [7:0]     mem [0:(1<<ASZ)-1];
  logic [7:0]     tib_b [0:255];
  logic           ld_en = 1'b0;
  logic [ASZ-1:0] ld_a = '0;
  logic [7:0]     ld_d = '0;
  int             we_cnt = 0, bad_rd = 0;
  int             tests = 0, fails = 0;
  logic [7:0]     last_len = '0, last_toin = '0;
  exp_t           sbq [$];

  mb8_io #(.ASZ(ASZ), .DSZ(DSZ)) mb ();

  parser #(.DSZ(DSZ), .ASZ(ASZ), .TMAX(TMAX)) dut (
    .clk(clk), .rst_n(rst_n), .mb_if(mb), .en(en), .tib(tib_a), .ntib(ntib),
    .toin(toin), .buf_addr(buf_a), .dlm(dlm), .vw(vw), .bsy(bsy), .ok(ok),
    .len(len), .trc(trc), .toin_o(toin_o), .st(st)
  );

  always #5 clk = ~clk;

  // Memory block: registered read, write on the edge where we is high.
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mb.we) mem[mb.ai] <= mb.vo;
    vw <= mem[mb.ai];
    if (mb.we) we_cnt <= we_cnt + 1;
    if (bsy && !mb.we && mb.ai >= tib_a + ASZ'(ntib) && mb.ai < buf_a) bad_rd <= bad_rd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_mem(input logic [ASZ-1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_a = a; ld_d = d; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic put(input int i, input logic [7:0] b);
    tib_b[i] = b;
    wr_mem(TIB + ASZ'(i), b);
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) put(i, s[i]);
  endtask

  function automatic logic isd(input logic [7:0] b);
    if (dlm == 8'h20) return (b == 8'h20 || b == 8'h09 || b == 8'h0a || b == 8'h0d || b < 8'h20);
    return b == dlm;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int idx, s, c;
    e = '0; idx = int'(toin); s = 0; c = 0;
    while (idx < int'(ntib) && isd(tib_b[idx])) begin idx++; s++; end
    if (idx >= int'(ntib)) e.lat = 16'(3 + 3 * s);
    else begin
      while (idx < int'(ntib) && !isd(tib_b[idx])) begin
        if (c < TMAX) e.ch[c] = tib_b[idx];
        c++; idx++;
      end
      if (idx < int'(ntib)) begin idx++; e.lat = 16'(1 + 3 * s + 4 * c + 4); end
      else e.lat = 16'(1 + 3 * s + 4 * c + 2);
    end
    e.len  = 8'((c > TMAX) ? TMAX : c);
    e.trc  = (c > TMAX);
    e.ok   = (c != 0);
    e.toin = 8'(idx);
    return e;
  endfunction

  task automatic run_op(input string tag);
    exp_t e, g;
    int k, w0, r0;
    for (int i = 0; i <= TMAX + 1; i++) wr_mem(BUF + ASZ'(i), 8'hEE);
    e = model();
    sbq.push_back(e);
    w0 = we_cnt; r0 = bad_rd;
    @(negedge clk);
    en = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (bsy && k < 600);
    chk({tag, "_timeout"}, {31'd0, bsy}, 32'd0);
    g = sbq.pop_front();
    chk({tag, "_lat"}, k, g.lat);
    chk({tag, "_ok"}, {31'd0, ok}, {31'd0, g.ok});
    chk({tag, "_len"}, {24'd0, len}, {24'd0, g.len});
    chk({tag, "_trc"}, {31'd0, trc}, {31'd0, g.trc});
    chk({tag, "_toin"}, {24'd0, toin_o}, {24'd0, g.toin});
    @(posedge clk); #1;
    chk({tag, "_wecnt"}, we_cnt - w0, int'(g.len) + 1);
    chk({tag, "_badrd"}, bad_rd - r0, 0);
    chk({tag, "_mlen"}, {24'd0, mem[BUF]}, {24'd0, g.len});
    for (int i = 0; i < int'(g.len); i++)
      chk({tag, "_mch"}, {24'd0, mem[BUF + ASZ'(i) + 1]}, {24'd0, g.ch[i]});
    chk({tag, "_mtail"}, {24'd0, mem[BUF + ASZ'(g.len) + 1]}, 32'hEE);
    last_len = g.len; last_toin = g.toin;
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {28'd0, st}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bsy", {31'd0, bsy}, 0);
    chk("rst_ok", {31'd0, ok}, 0);
    chk("rst_len", {24'd0, len}, 0);
    chk("rst_toin", {24'd0, toin_o}, 0);
    chk("rst_we", {31'd0, mb.we}, 0);
    chk("rst_ai", {15'd0, mb.ai}, 0);
    chk("rst_st", {28'd0, st}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    load("DUP "); ntib = 8'd4; toin = 8'd0; dlm = 8'h20;
    run_op("dup");

    load("  \tSWAP"); ntib = 8'd7; toin = 8'd0;
    run_op("swap");

    load("hello"); ntib = 8'd5; toin = 8'd5;
    run_op("empty");
    chk("empty_ok_lat", {16'd0, 16'(3)}, {16'd0, model().lat});

    for (int i = 0; i < 40; i++) put(i, 8'(8'h41 + 8'(i % 26)));
    put(40, 8'h20); ntib = 8'd41; toin = 8'd0;
    run_op("trunc");

    load("abc) x"); ntib = 8'd6; toin = 8'd0; dlm = 8'h29;
    run_op("paren");
    load("a b)"); ntib = 8'd4;
    run_op("paren_sp");

    load("DUP SWAP"); ntib = 8'd8; toin = 8'd4; dlm = 8'h20;
    run_op("toin4");

    load("DUP "); ntib = 8'd4; toin = 8'd0;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (st == 4'd4) break;
    end
    chk("abort_reach", {28'd0, st}, 32'd4);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("abort_bsy", {31'd0, bsy}, 0);
    chk("abort_we", {31'd0, mb.we}, 0);
    chk("abort_ok", {31'd0, ok}, 0);
    chk("abort_st", {28'd0, st}, 0);
    chk("abort_len", {24'd0, len}, {24'd0, last_len});
    chk("abort_toin", {24'd0, toin_o}, {24'd0, last_toin});

    @(negedge clk);
    en = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0; en = 1'b0;
    #1;
    chk("arst_bsy", {31'd0, bsy}, 0);
    chk("arst_len", {24'd0, len}, 0);
    chk("arst_toin", {24'd0, toin_o}, 0);
    chk("arst_ai", {15'd0, mb.ai}, 0);
    chk("arst_we", {31'd0, mb.we}, 0);
    chk("arst_vo", {24'd0, mb.vo}, 0);
    chk("arst_st", {28'd0, st}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
